// File: rtl/mux_arb_pkg.sv
// Shared encodings for the 2:1 mux select arbiter: FSM state codes and
// source IDs (the source IDs are also the mux select values).
package mux_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GA   = 2'd1;
    localparam logic [1:0] ST_GB   = 2'd2;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT_A = ST_GA,
        GRANT_B = ST_GB
    } arb_state_e;

endpackage

// File: rtl/mux_grant_cnt.sv
// Grant-age counter: clears on grant entry, counts while a grant is held,
// saturates at SAT and flags the hold and pre-emption thresholds.
module mux_grant_cnt
    import mux_arb_pkg::*;
#(
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned SAT         = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hold_done_o,
    output logic             max_hit_o
);

    localparam logic [CNT_W-1:0] SAT_V  = CNT_W'(SAT);
    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT_V)) begin
            cnt_d = cnt_q + ONE_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign hold_done_o = (cnt_q >= HOLD_V);
    assign max_hit_o   = (cnt_q == SAT_V);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source arbiter driving a 2:1 mux select, with minimum grant hold,
// maximum grant under contention and round-robin tie breaking.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned MAX_GRANT   = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] cnt_dbg
);

    // Handshake: req_x is a level request sampled on each rising edge;
    // gnt_x is the registered answer one edge later and stays high at least
    // HOLD_CYCLES cycles even if req_x drops.

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       sel_q, sel_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       busy_q, busy_d;
    logic       cnt_clr, cnt_en;
    logic       hold_done, max_hit;
    logic [CNT_W-1:0] cnt;

    mux_grant_cnt #(
        .CNT_W       (CNT_W),
        .SAT         (MAX_GRANT - 1),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .en_i        (cnt_en),
        .cnt_o       (cnt),
        .hold_done_o (hold_done),
        .max_hit_o   (max_hit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_q == SRC_A) ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    state_d = GRANT_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!hold_done) begin
                    state_d = GRANT_A;
                end else if (req_a && !(req_b && max_hit)) begin
                    state_d = GRANT_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT_B: begin
                if (!hold_done) begin
                    state_d = GRANT_B;
                end else if (req_b && !(req_a && max_hit)) begin
                    state_d = GRANT_B;
                end else if (req_a) begin
                    state_d = GRANT_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        last_d  = last_q;
        sel_d   = sel_q;
        if (state_d == GRANT_A) begin
            sel_d = SRC_A;
            if (state_q != GRANT_A) last_d = SRC_A;
        end else if (state_d == GRANT_B) begin
            sel_d = SRC_B;
            if (state_q != GRANT_B) last_d = SRC_B;
        end
        gnt_a_d = (state_d == GRANT_A);
        gnt_b_d = (state_d == GRANT_B);
        busy_d  = gnt_a_d | gnt_b_d;
        cnt_clr = (state_d != state_q);
        cnt_en  = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC_B;
            sel_q   <= SRC_A;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
    assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: linear steps with hand-computed
// {state, sel, gnt_a, gnt_b, busy} vectors queued and checked per edge.
module tb_mux_sel_arbiter;

    // Expected vector layout: {state[1:0], sel, gnt_a, gnt_b, busy}
    localparam logic [5:0] E_IDLE0 = 6'b00_0_000;
    localparam logic [5:0] E_IDLE1 = 6'b00_1_000;
    localparam logic [5:0] E_A     = 6'b01_0_101;
    localparam logic [5:0] E_B     = 6'b10_1_011;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       sel;
    logic       gnt_a;
    logic       gnt_b;
    logic       busy;
    logic [1:0] state_dbg;
    logic [2:0] cnt_dbg;

    logic [5:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    mux_sel_arbiter #(
        .HOLD_CYCLES (2),
        .MAX_GRANT   (4),
        .CNT_W       (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .sel       (sel),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .busy      (busy),
        .state_dbg (state_dbg),
        .cnt_dbg   (cnt_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {state_dbg, sel, gnt_a, gnt_b, busy};
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [2:0] exp_c);
        n_checks++;
        assert (cnt_dbg === exp_c) else begin
            n_fail++;
            $error("FAIL %s: observed cnt %0d expected %0d", tag, cnt_dbg, exp_c);
        end
    endtask

    // Driver: set requests at negedge, check outputs just after the next posedge
    task automatic step(input logic ra, input logic rb, input logic [5:0] exp_v,
                        input string tag);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req_a    = 1'b0;
        req_b    = 1'b0;

        #1;
        exp_q.push_back(E_IDLE0);
        check("reset_state");
        check_cnt("reset_cnt", 3'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single one-cycle pulse on A: held exactly 2 cycles
        step(1'b1, 1'b0, E_A,     "pulse_a_c0");
        step(1'b0, 1'b0, E_A,     "pulse_a_c1");
        step(1'b0, 1'b0, E_IDLE0, "pulse_idle");
        step(1'b0, 1'b0, E_IDLE0, "pulse_idle2");

        // Sustained B for 10 cycles; counter saturates at 3
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, E_B, $sformatf("sust_b_%0d", i));
        end
        check_cnt("sust_b_sat", 3'd3);
        step(1'b0, 1'b0, E_IDLE1, "sust_b_end");
        step(1'b0, 1'b0, E_IDLE1, "sust_b_sel_hold");

        // Async reset in the middle of a B grant
        step(1'b0, 1'b1, E_B, "pre_rst_b");
        #2;
        rst   = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        #1;
        exp_q.push_back(E_IDLE0);
        check("rst_async");
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(E_A);
        @(posedge clk);
        #1;
        check("rst_rel_a");
        check_cnt("rst_rel_cnt", 3'd0);

        // Contention round-robin: A x4, B x4, A x4
        for (int i = 1; i < 4; i++) step(1'b1, 1'b1, E_A, $sformatf("rr_a1_%0d", i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, E_B, $sformatf("rr_b_%0d", i));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, E_A, $sformatf("rr_a2_%0d", i));
        step(1'b0, 1'b0, E_IDLE0, "rr_idle");

        // Late contender: B rises in A's 2nd cycle, pre-empts after A's 4th
        step(1'b1, 1'b0, E_A, "late_a0");
        step(1'b1, 1'b0, E_A, "late_a1");
        step(1'b1, 1'b1, E_A, "late_a2");
        step(1'b1, 1'b1, E_A, "late_a3");
        step(1'b1, 1'b1, E_B, "late_b0");
        step(1'b1, 1'b0, E_B, "late_b1");
        step(1'b1, 1'b0, E_A, "late_back_a");
        step(1'b0, 1'b0, E_A, "late_back_a1");
        step(1'b0, 1'b0, E_IDLE0, "late_idle");

        // Early drop: A held through hold, then direct switch to B
        step(1'b1, 1'b0, E_A,     "early_a0");
        step(1'b0, 1'b1, E_A,     "early_a1");
        step(1'b0, 1'b1, E_B,     "early_switch_b");
        check_cnt("early_switch_cnt", 3'd0);
        step(1'b0, 1'b0, E_B,     "early_b1");
        step(1'b0, 1'b0, E_IDLE1, "early_idle");

        // Tie from IDLE after B was last served: A wins
        step(1'b1, 1'b1, E_A, "tie_after_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
